// File: rtl/vga_timing_gen_pkg.sv
// VGA 640x400 timing constants, widths and the registered output bundle.
// Imported by the horizontal counter and the timing decode stage.
package vga_timing_gen_pkg;

    localparam int HCNT_W = 10;
    localparam int VCNT_W = 9;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 400;
    localparam int V_FP      = 12;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 36;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic HSYNC_POL = 1'b0;
    localparam logic VSYNC_POL = 1'b1;

    localparam logic [HCNT_W-1:0] H_LAST =
        HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_VIS_END =
        HCNT_W'(H_VISIBLE);
    localparam logic [HCNT_W-1:0] H_SYNC_START =
        HCNT_W'(H_VISIBLE + H_FP);
    localparam logic [HCNT_W-1:0] H_SYNC_END =
        HCNT_W'(H_VISIBLE + H_FP + H_SYNC);

    localparam logic [VCNT_W-1:0] V_VIS_END =
        VCNT_W'(V_VISIBLE);
    localparam logic [VCNT_W-1:0] V_SYNC_START =
        VCNT_W'(V_VISIBLE + V_FP);
    localparam logic [VCNT_W-1:0] V_SYNC_END =
        VCNT_W'(V_VISIBLE + V_FP + V_SYNC);

    typedef struct packed {
        logic              hsync;
        logic              vsync;
        logic              video_on;
        logic [HCNT_W-1:0] pixel_x;
        logic [VCNT_W-1:0] pixel_y;
        logic              frame_start;
    } vga_out_t;

    localparam vga_out_t VGA_OUT_RST = '{
        hsync:       ~HSYNC_POL,
        vsync:       ~VSYNC_POL,
        video_on:    1'b0,
        pixel_x:     '0,
        pixel_y:     '0,
        frame_start: 1'b0
    };

    // Sync level for a given active/inactive decode.
    function automatic logic sync_level(
        input logic active,
        input logic pol
    );
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_hcnt.sv
// Horizontal pixel counter 0..H_TOTAL-1 advancing on pix_en.
// Ports: vga_clk, reset (async low), pix_en in; hcnt, VcntEnable out.
module vga_timing_gen_hcnt
    import vga_timing_gen_pkg::*;
(
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              pix_en,
    output logic [HCNT_W-1:0] hcnt,
    output logic              VcntEnable
);

    logic at_last;

    assign at_last = (hcnt == H_LAST);

    // Combinational so the line counter steps on the wrap edge.
    assign VcntEnable = pix_en && at_last;

    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            hcnt <= '0;
        end else if (pix_en) begin
            if (at_last) begin
                hcnt <= '0;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Horizontal timing stage: pixel counter plus registered sync/video decode.
// Ports: vga_clk, reset, pix_en, VcntValue in; VcntEnable, syncs, pixel out.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
(
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic [VCNT_W-1:0] VcntValue,
    output logic              VcntEnable,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic [HCNT_W-1:0] pixel_x,
    output logic [VCNT_W-1:0] pixel_y,
    output logic              frame_start
);

    logic [HCNT_W-1:0] hcnt;
    logic              h_vis;
    logic              v_vis;
    logic              h_act;
    logic              v_act;
    vga_out_t          nxt;
    vga_out_t          q;

    vga_timing_gen_hcnt u_hcnt (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .hcnt       (hcnt),
        .VcntEnable (VcntEnable)
    );

    // Out-of-range line values fall outside both windows,
    // so they decode as blanking with vsync inactive.
    always_comb begin
        h_vis = (hcnt < H_VIS_END);
        v_vis = (VcntValue < V_VIS_END);
        h_act = (hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END);
        v_act = (VcntValue >= V_SYNC_START) &&
                (VcntValue < V_SYNC_END);

        nxt             = VGA_OUT_RST;
        nxt.hsync       = sync_level(h_act, HSYNC_POL);
        nxt.vsync       = sync_level(v_act, VSYNC_POL);
        nxt.video_on    = h_vis && v_vis;
        nxt.pixel_x     = nxt.video_on ? hcnt : '0;
        nxt.pixel_y     = nxt.video_on ? VcntValue : '0;
        nxt.frame_start = (hcnt == '0) && (VcntValue == '0);
    end

    // frame_start clears on idle ticks so it never stretches
    // beyond one clock while pix_en is low.
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            q <= VGA_OUT_RST;
        end else if (pix_en) begin
            q <= nxt;
        end else begin
            q.frame_start <= 1'b0;
        end
    end

    assign hsync       = q.hsync;
    assign vsync       = q.vsync;
    assign video_on    = q.video_on;
    assign pixel_x     = q.pixel_x;
    assign pixel_y     = q.pixel_y;
    assign frame_start = q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen with a line-counter stand-in.
// Reference model: plain arithmetic on the current (column, line) pair.
module tb_vga_timing_gen;

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       pix_en  = 1'b0;
    logic [8:0] VcntValue;
    logic       VcntEnable;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [8:0] pixel_y;
    logic       frame_start;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .VcntValue   (VcntValue),
        .VcntEnable  (VcntEnable),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start)
    );

    // Line counter stand-in, optionally preloaded or overridden.
    logic [8:0] vc;
    logic       load_req  = 1'b0;
    logic [8:0] load_val  = '0;
    logic       force_en  = 1'b0;
    logic [8:0] force_val = '0;

    always @(posedge vga_clk or negedge reset) begin
        if (!reset) vc <= '0;
        else if (load_req) vc <= load_val;
        else if (VcntEnable) vc <= (vc == 9'd449) ? 9'd0 : vc + 9'd1;
    end

    assign VcntValue = force_en ? force_val : vc;

    typedef struct {
        bit hs;
        bit vs;
        bit vo;
        int px;
        int py;
        bit fs;
    } exp_t;

    exp_t q[$];
    exp_t last;

    int checks = 0;
    int errors = 0;
    int mh = 0;

    bit win = 0;
    bit first_px_chk = 0;
    int win_idx = 0;
    int vo_cnt = 0;
    int hs_lo_cnt = 0;
    int vs_hi_cnt = 0;
    int fs_cnt = 0;
    int ve_cnt = 0;
    int first_hs = -1;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: decides what the next edge must register.
    initial begin
        int v;
        bit ve;
        last = '{hs: 1, vs: 0, vo: 0, px: 0, py: 0, fs: 0};
        forever begin
            @(negedge vga_clk);
            #3;
            ve = reset && pix_en && (mh == 799);
            chk("vcnt_enable", VcntEnable, ve);
            if (win && ve) ve_cnt++;
            if (!reset) begin
                mh = 0;
                last = '{hs: 1, vs: 0, vo: 0, px: 0, py: 0, fs: 0};
            end else if (pix_en) begin
                v = int'(VcntValue);
                last.hs = (mh >= 656 && mh < 752) ? 1'b0 : 1'b1;
                last.vs = (v >= 412 && v < 414) ? 1'b1 : 1'b0;
                last.vo = (mh < 640) && (v < 400);
                last.px = last.vo ? mh : 0;
                last.py = last.vo ? v : 0;
                last.fs = (mh == 0) && (v == 0);
                mh = (mh + 1) % 800;
            end else begin
                last.fs = 0;
            end
            q.push_back(last);
        end
    end

    // Monitor: compares every registered output after each edge.
    initial begin
        exp_t e;
        @(negedge vga_clk);
        forever begin
            @(posedge vga_clk);
            #1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got 0 expected 1");
            end else begin
                e = q.pop_front();
                chk("hsync", hsync, e.hs);
                chk("vsync", vsync, e.vs);
                chk("video_on", video_on, e.vo);
                chk("pixel_x", pixel_x, e.px);
                chk("pixel_y", pixel_y, e.py);
                chk("frame_start", frame_start, e.fs);
            end
            if (win) begin
                win_idx++;
                if (first_px_chk && win_idx == 1) begin
                    chk("first_px_after_reset", pixel_x, 0);
                    chk("first_vo_after_reset", video_on, 1);
                end
                if (video_on === 1'b1) vo_cnt++;
                if (hsync === 1'b0) begin
                    hs_lo_cnt++;
                    if (first_hs < 0) first_hs = win_idx - 1;
                end
                if (vsync === 1'b1) vs_hi_cnt++;
                if (frame_start === 1'b1) fs_cnt++;
            end
        end
    end

    task automatic clear_win();
        win_idx = 0;
        vo_cnt = 0;
        hs_lo_cnt = 0;
        vs_hi_cnt = 0;
        fs_cnt = 0;
        ve_cnt = 0;
        first_hs = -1;
    endtask

    task automatic reset_now();
        reset = 1'b0;
        #1;
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 0);
        chk("rst_video_on", video_on, 0);
        chk("rst_pixel_x", pixel_x, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_vcnt_enable", VcntEnable, 0);
    endtask

    // Reset, then release with pix_en low while the line
    // counter stand-in loads its start value.
    task automatic do_reset(input logic [8:0] lv);
        @(negedge vga_clk);
        pix_en = 1'b0;
        reset_now();
        repeat (2) @(negedge vga_clk);
        reset = 1'b1;
        load_req = 1'b1;
        load_val = lv;
        @(negedge vga_clk);
        load_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        #2;
        reset_now();
        repeat (3) @(negedge vga_clk);
        reset = 1'b1;

        // Random pix_en, closed loop.
        for (int i = 0; i < 2000; i++) begin
            @(negedge vga_clk);
            pix_en = ($urandom % 4) != 0;
        end

        // Reset in the middle of a line.
        hit = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge vga_clk);
            if (mh == 300) begin
                hit = 1;
                break;
            end
            pix_en = 1'b1;
        end
        chk("reach_h300", hit, 1);
        pix_en = 1'b0;
        reset_now();
        repeat (2) @(negedge vga_clk);

        // One full line on line 10.
        clear_win();
        reset = 1'b1;
        force_en = 1'b1;
        force_val = 9'd10;
        pix_en = 1'b1;
        first_px_chk = 1;
        win = 1;
        repeat (800) @(negedge vga_clk);
        win = 0;
        first_px_chk = 0;
        chk("line_video_on_cycles", vo_cnt, 640);
        chk("line_hsync_low_cycles", hs_lo_cnt, 96);
        chk("line_hsync_first_h", first_hs, 656);
        chk("line_vcnt_enable_pulses", ve_cnt, 1);

        // Out-of-range line value.
        clear_win();
        force_val = 9'd500;
        win = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge vga_clk);
            pix_en = ($urandom % 3) != 0;
        end
        @(negedge vga_clk);
        win = 0;
        chk("oor_video_on_cycles", vo_cnt, 0);
        chk("oor_vsync_cycles", vs_hi_cnt, 0);
        force_en = 1'b0;

        // Alternating pix_en from (0,0).
        do_reset(9'd0);
        clear_win();
        win = 1;
        for (int i = 0; i < 1700; i++) begin
            @(negedge vga_clk);
            pix_en = (i % 2) == 0;
        end
        @(negedge vga_clk);
        win = 0;
        chk("toggle_frame_start_cycles", fs_cnt, 1);

        // Closed loop across vsync and the frame wrap.
        do_reset(9'd405);
        clear_win();
        pix_en = 1'b1;
        win = 1;
        repeat (47 * 800) @(negedge vga_clk);
        win = 0;
        chk("frame_vsync_cycles", vs_hi_cnt, 1600);
        chk("frame_start_count", fs_cnt, 1);
        chk("frame_vcnt_enable_pulses", ve_cnt, 47);
        pix_en = 1'b0;
        repeat (3) @(negedge vga_clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Horizontal timing stage of the VGA display pipeline. It runs the pixel counter, issues the one-cycle `VcntEnable` advance strobe to the vertical line counter at the end of each line, and takes back that counter's `VcntValue`. From the two counts it produces registered `hsync`, `vsync`, `video_on`, pixel coordinates and a frame-start pulse for the pixel source and the DAC interface. The timing is the 640x400 mode: 800 clocks per line, 450 lines per frame (line count 0..449).

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync width (clocks)
- `H_BP`, 48, horizontal back porch; `H_TOTAL` = sum = 800
- `V_VISIBLE`, 400, visible lines
- `V_FP`, 12, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 36, vertical back porch; `V_TOTAL` = sum = 450
- `HSYNC_POL`, 0, active level of `hsync`
- `VSYNC_POL`, 1, active level of `vsync`

Ports:
- `vga_clk`  in  1  pixel-domain clock; the only clock
- `reset`  in  1  asynchronous, active-low reset
- `pix_en`  in  1  pixel tick; all state advances only on cycles where it is 1
- `VcntValue`  in  9  current line, 0..449, from the vertical counter
- `VcntEnable`  out  1  combinational: `pix_en && hcnt == H_TOTAL-1`
- `hsync`  out  1  registered horizontal sync
- `vsync`  out  1  registered vertical sync
- `video_on`  out  1  registered; 1 inside the visible 640x400 window
- `pixel_x`  out  10  registered column, 0..639 when `video_on`, else 0
- `pixel_y`  out  9  registered row, 0..399 when `video_on`, else 0
- `frame_start`  out  1  registered one-cycle pulse for pixel (0,0)

## Operation
- `hcnt` is 10 bits wide, range 0..H_TOTAL-1.
  - Increments on each `pix_en` cycle.
  - At H_TOTAL-1 it wraps to 0 on the same edge that the vertical counter sees `VcntEnable`.
- `VcntEnable` is purely combinational from `hcnt` and `pix_en`, so that `VcntValue` changes exactly when `hcnt` wraps. It is asserted once per line, for exactly one `vga_clk` cycle.
- Decode, registered when `pix_en` = 1 and held otherwise:
  - hsync active when H_VISIBLE+H_FP ≤ hcnt < H_VISIBLE+H_FP+H_SYNC (656..751). Output is `HSYNC_POL` when active, its inverse otherwise.
  - vsync active when V_VISIBLE+V_FP ≤ VcntValue < V_VISIBLE+V_FP+V_SYNC (412..413). Output is `VSYNC_POL` when active, its inverse otherwise.
  - `video_on` = (hcnt < 640) && (VcntValue < 400).
  - `pixel_x` = `hcnt` and `pixel_y` = `VcntValue` when `video_on`, else 0.
  - `frame_start` = (hcnt == 0 && VcntValue == 0). It is additionally qualified so that it is high for one `vga_clk` cycle only, even if `pix_en` stays low afterwards.
- A `VcntValue` ≥ V_TOTAL (out of range) is treated as blanking: `video_on` = 0 and vsync inactive. There is no error flag.

## Timing
- Reset (`reset` = 0, asynchronous):
  - `hcnt` = 0.
  - `hsync` = ~HSYNC_POL and `vsync` = ~VSYNC_POL (inactive).
  - `video_on`, `pixel_x`, `pixel_y`, `frame_start` = 0.
  - `VcntEnable` = 0, because `hcnt` is 0.
- Release is synchronous in effect: the first advance happens on the first `pix_en` edge after `reset` rises.
- Latency: registered outputs describe the (`hcnt`, `VcntValue`) pair present during the `pix_en` cycle, and appear after 1 `vga_clk` edge.
- `pix_en` = 0: every register holds, `VcntEnable` = 0, and `frame_start` drops after 1 cycle.
- Reset asserted mid-line or mid-frame: outputs go to their reset values immediately. The vertical counter shares `reset`, so both restart at (0,0).
- Line wrap (hcnt 799 → 0) and frame wrap (VcntValue 449 → 0) happen on the same edge. The next decode sees (0,0).

## Structure
- Shared header `vga_timing_defs.vh`:
  - the H/V porch, sync and total constants;
  - the sync polarities;
  - the widths `HCNT_W` = 10 and `VCNT_W` = 9.
- Sub-module `HorizontalCnt`: the `hcnt` counter with `pix_en` and wrap, producing `VcntEnable`. It mirrors the existing vertical counter.
- Top-level: the decode registers. The vertical counter is instantiated alongside this block at the display top level, not inside it.

## Test plan
- Reset mid-line (hcnt = 300): assert `reset` = 0.
  - Outputs take their reset values without waiting for a clock edge: `hsync` = 1, `vsync` = 0, `video_on` = 0.
  - After release, with `pix_en` = 1, the first `pixel_x` = 0.
- Full line with `pix_en` = 1 and `VcntValue` = 10:
  - `video_on` is high for 640 cycles;
  - `hsync` is low for exactly 96 cycles, starting at decode hcnt 656;
  - `VcntEnable` pulses once, at hcnt 799.
- Closed loop with the vertical counter for 2 frames:
  - 360,000 clocks per frame;
  - `vsync` is high for 1,600 clocks (lines 412..413);
  - `frame_start` occurs exactly once per frame.
- `pix_en` toggling 1,0,1,0: the counters advance every other clock and each output holds during the 0 cycles. Pixel 639→640 drops `video_on` one `pix_en` cycle later.
- Forced `VcntValue` = 500: `video_on` = 0 and `vsync` inactive for the whole line, with no X propagation.
- Frame boundary (hcnt = 799, `VcntValue` = 449):
  - `VcntEnable` = 1;
  - the next decode gives `pixel_x` = 0, `pixel_y` = 0, `frame_start` = 1 for one cycle.
